// File: rtl/ex_stage_mc_pkg.sv
// rtl/ex_stage_mc_pkg.sv - shared opcodes and FSM state type for the execute stage
package ex_stage_mc_pkg;

  // Stage control states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ex_state_e;

  // Opcode values, compared after zero-extension to 32 bits so any OP_W works
  localparam logic [31:0] OPC_LDW  = 32'd1;
  localparam logic [31:0] OPC_SDW  = 32'd2;
  localparam logic [31:0] OPC_ADD  = 32'd3;
  localparam logic [31:0] OPC_ADDI = 32'd4;
  localparam logic [31:0] OPC_SUB  = 32'd5;
  localparam logic [31:0] OPC_AND  = 32'd6;
  localparam logic [31:0] OPC_OR   = 32'd7;
  localparam logic [31:0] OPC_XOR  = 32'd8;
  localparam logic [31:0] OPC_SLT  = 32'd9;
  localparam logic [31:0] OPC_MUL  = 32'd10;
  localparam logic [31:0] OPC_MULH = 32'd11;

  // Ops whose B operand comes from the immediate field
  function automatic logic uses_imm(input logic [31:0] opc);
    return (opc == OPC_LDW) || (opc == OPC_SDW) || (opc == OPC_ADDI);
  endfunction

  // Ops handled by the iterative multiplier
  function automatic logic is_mul_op(input logic [31:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_MULH);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - iterative unsigned shift-add multiplier, MUL_K bits per cycle
module ex_mul_iter #(
  parameter int XLEN  = 32,
  parameter int MUL_K = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] prod_hi,
  output logic [XLEN-1:0] prod_lo
);

  localparam int STEPS = XLEN / MUL_K;
  localparam int CW    = $clog2(STEPS + 1);

  // acc_q low half starts as the multiplier and is consumed MUL_K bits at a
  // time from the bottom while the partial product grows in from the top.
  logic [XLEN-1:0]       mcand_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [2*XLEN-1:0]     acc_d;
  logic [CW-1:0]         cnt_q;
  logic [XLEN+MUL_K-1:0] partial;
  logic [XLEN+MUL_K-1:0] sum;

  // One radix-2^MUL_K step: add multiplicand times the low digit, shift right
  always_comb begin
    partial = {{MUL_K{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[MUL_K-1:0]};
    sum     = {{MUL_K{1'b0}}, acc_q[2*XLEN-1:XLEN]} + partial;
    acc_d   = {sum, acc_q[XLEN-1:MUL_K]};
  end

  // The product is presented combinationally on the final step so the
  // stage can capture it on the same edge the counter reaches zero.
  assign done              = (cnt_q == CW'(1));
  assign {prod_hi, prod_lo} = acc_d;

  // Operand load, stepping and abort
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (start) begin
      mcand_q <= a;
      acc_q   <= {{XLEN{1'b0}}, b};
      cnt_q   <= CW'(STEPS);
    end else if (cnt_q != '0) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - handshaked execute stage with single-cycle ALU and iterative multiplier
module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int OP_W  = 6,
  parameter int MUL_K = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] val_rs_in,
  input  logic [XLEN-1:0] val_rt_in,
  input  logic [RA_W-1:0] rwd_in,
  input  logic [OP_W-1:0] opcode_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] val_rt_out,
  output logic [RA_W-1:0] rwd_out,
  output logic [OP_W-1:0] opcode_out,
  output logic [XLEN-1:0] alu_res_out,
  output logic            zf_out,
  output logic            busy
);

  ex_state_e       state_q, state_d;
  logic [31:0]     opc;
  logic [XLEN-1:0] b_op;
  logic [XLEN-1:0] alu_res;
  logic            accept, is_mul, mul_start, mul_done;
  logic [XLEN-1:0] prod_hi, prod_lo, mul_res;
  logic [XLEN-1:0] pend_rt;
  logic [RA_W-1:0] pend_rwd;
  logic [OP_W-1:0] pend_op;

  assign opc       = 32'(opcode_in);
  assign busy      = (state_q == ST_BUSY);
  assign in_ready  = !busy && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = is_mul_op(opc);
  assign mul_start = accept && is_mul;
  assign b_op      = uses_imm(opc) ? imm_in : val_rt_in;
  assign mul_res   = (32'(pend_op) == OPC_MULH) ? prod_hi : prod_lo;

  // Single-cycle ALU; unknown and multiply opcodes yield zero here
  always_comb begin
    alu_res = '0;
    case (opc)
      OPC_ADD, OPC_ADDI, OPC_LDW, OPC_SDW: alu_res = val_rs_in + b_op;
      OPC_SUB: alu_res = val_rs_in - b_op;
      OPC_AND: alu_res = val_rs_in & b_op;
      OPC_OR:  alu_res = val_rs_in | b_op;
      OPC_XOR: alu_res = val_rs_in ^ b_op;
      OPC_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(val_rs_in) < $signed(b_op))};
      default: alu_res = '0;
    endcase
  end

  ex_mul_iter #(
    .XLEN (XLEN),
    .MUL_K(MUL_K)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (mul_start),
    .a      (val_rs_in),
    .b      (b_op),
    .done   (mul_done),
    .prod_hi(prod_hi),
    .prod_lo(prod_lo)
  );

  // Next-state logic: enter BUSY on a multiply accept, leave on completion or flush
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_BUSY;
      ST_BUSY: if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output slot and multiply side-band; flush only drops valid, data stays stale
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      val_rt_out  <= '0;
      rwd_out     <= '0;
      opcode_out  <= '0;
      alu_res_out <= '0;
      zf_out      <= 1'b0;
      pend_rt     <= '0;
      pend_rwd    <= '0;
      pend_op     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out_valid   <= 1'b1;
        val_rt_out  <= val_rt_in;
        rwd_out     <= rwd_in;
        opcode_out  <= opcode_in;
        alu_res_out <= alu_res;
        zf_out      <= (alu_res == '0);
      end
      if (mul_start) begin
        pend_rt  <= val_rt_in;
        pend_rwd <= rwd_in;
        pend_op  <= opcode_in;
      end
      if (busy && mul_done) begin
        out_valid   <= 1'b1;
        val_rt_out  <= pend_rt;
        rwd_out     <= pend_rwd;
        opcode_out  <= pend_op;
        alu_res_out <= mul_res;
        zf_out      <= (mul_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - self-checking bench for ex_stage_mc
module tb_ex_stage_mc;
  import ex_stage_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (MUL_K = 1)
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zf_out, busy;
  logic [31:0] imm_in, val_rs_in, val_rt_in, val_rt_out, alu_res_out;
  logic [4:0]  rwd_in, rwd_out;
  logic [5:0]  opcode_in, opcode_out;

  // Second instance (MUL_K = 4)
  logic        k_rst, k_flush, k_in_valid, k_in_ready, k_out_valid, k_out_ready, k_zf, k_busy;
  logic [31:0] k_imm, k_rs, k_rt, k_rt_out, k_res;
  logic [4:0]  k_rwd_in, k_rwd_out;
  logic [5:0]  k_op_in, k_op_out;

  ex_stage_mc u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm_in(imm_in), .val_rs_in(val_rs_in), .val_rt_in(val_rt_in), .rwd_in(rwd_in),
    .opcode_in(opcode_in), .out_valid(out_valid), .out_ready(out_ready),
    .val_rt_out(val_rt_out), .rwd_out(rwd_out), .opcode_out(opcode_out),
    .alu_res_out(alu_res_out), .zf_out(zf_out), .busy(busy)
  );

  ex_stage_mc #(.MUL_K(4)) u_dut4 (
    .clk(clk), .rst(k_rst), .flush(k_flush), .in_valid(k_in_valid), .in_ready(k_in_ready),
    .imm_in(k_imm), .val_rs_in(k_rs), .val_rt_in(k_rt), .rwd_in(k_rwd_in),
    .opcode_in(k_op_in), .out_valid(k_out_valid), .out_ready(k_out_ready),
    .val_rt_out(k_rt_out), .rwd_out(k_rwd_out), .opcode_out(k_op_out),
    .alu_res_out(k_res), .zf_out(k_zf), .busy(k_busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] rwd);
    in_valid  = 1'b1;
    opcode_in = 6'(op);
    val_rs_in = rs;
    val_rt_in = rt;
    imm_in    = imm;
    rwd_in    = rwd;
  endtask

  // Reference result straight from the opcode definitions
  function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] imm);
    logic [63:0] full;
    full = {32'd0, rs} * {32'd0, rt};
    case (32'(op))
      OPC_ADD:                     return rs + rt;
      OPC_ADDI, OPC_LDW, OPC_SDW:  return rs + imm;
      OPC_SUB:                     return rs - rt;
      OPC_AND:                     return rs & rt;
      OPC_OR:                      return rs | rt;
      OPC_XOR:                     return rs ^ rt;
      OPC_SLT:                     return ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
      OPC_MUL:                     return full[31:0];
      OPC_MULH:                    return full[63:32];
      default:                     return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] op;
    logic [31:0] rs, rt, imm;
    logic [4:0]  rwd;
    logic [31:0] exp_res;
    logic        exp_zf;
  } vec_t;

  vec_t tbl[12];

  // Random-phase reference state
  bit          m_v, rdy, acc;
  int          m_left;
  logic [31:0] m_res, m_rt, p_res, p_rt, r;
  logic [4:0]  m_rwd, p_rwd;
  logic [5:0]  m_op, p_op;
  logic [5:0]  ops[13];

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OPC_ADD,  32'hFFFF_FFFF, 32'h2,         32'h100,       5'd1,  32'h0000_0001, 1'b0};
    tbl[1]  = '{OPC_SUB,  32'h5,         32'h5,         32'h0,         5'd2,  32'h0000_0000, 1'b1};
    tbl[2]  = '{OPC_LDW,  32'h1000,      32'hDEAD,      32'h24,        5'd3,  32'h0000_1024, 1'b0};
    tbl[3]  = '{OPC_SLT,  32'hFFFF_FFFE, 32'h1,         32'h0,         5'd4,  32'h0000_0001, 1'b0};
    tbl[4]  = '{OPC_SLT,  32'h1,         32'hFFFF_FFFE, 32'h0,         5'd5,  32'h0000_0000, 1'b1};
    tbl[5]  = '{OPC_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         5'd6,  32'hF000_F000, 1'b0};
    tbl[6]  = '{OPC_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0,         5'd7,  32'hFFFF_F0F0, 1'b0};
    tbl[7]  = '{OPC_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h0,         5'd8,  32'h5555_5555, 1'b0};
    tbl[8]  = '{OPC_ADDI, 32'h10,        32'h999,       32'hFFFF_FFFF, 5'd9,  32'h0000_000F, 1'b0};
    tbl[9]  = '{OPC_SDW,  32'h8,         32'h1234,      32'h4,         5'd10, 32'h0000_000C, 1'b0};
    tbl[10] = '{OPC_SUB,  32'h0,         32'h1,         32'h0,         5'd11, 32'hFFFF_FFFF, 1'b0};
    tbl[11] = '{32'h3F,   32'h5,         32'h6,         32'h0,         5'd12, 32'h0000_0000, 1'b1};

    ops = '{6'(OPC_LDW), 6'(OPC_SDW), 6'(OPC_ADD), 6'(OPC_ADDI), 6'(OPC_SUB), 6'(OPC_AND),
            6'(OPC_OR), 6'(OPC_XOR), 6'(OPC_SLT), 6'(OPC_MUL), 6'(OPC_MULH), 6'h00, 6'h3F};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm_in = '0; val_rs_in = '0; val_rt_in = '0; rwd_in = '0; opcode_in = '0;
    k_rst = 1'b1; k_flush = 1'b0; k_in_valid = 1'b0; k_out_ready = 1'b1;
    k_imm = '0; k_rs = '0; k_rt = '0; k_rwd_in = '0; k_op_in = '0;
    tick(); tick();
    rst = 1'b0; k_rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {val_rt_out, rwd_out, opcode_out, alu_res_out, zf_out, busy}, 0);
    check("reset_in_ready", in_ready, 1);

    // Back-to-back single-cycle vectors
    drive(tbl[0].op, tbl[0].rs, tbl[0].rt, tbl[0].imm, tbl[0].rwd);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_res", i), alu_res_out, tbl[i].exp_res);
      check($sformatf("vec%0d_zf", i), zf_out, tbl[i].exp_zf);
      check($sformatf("vec%0d_side", i), {val_rt_out, rwd_out, opcode_out},
            {tbl[i].rt, tbl[i].rwd, 6'(tbl[i].op)});
      if (i < 11) drive(tbl[i+1].op, tbl[i+1].rs, tbl[i+1].rt, tbl[i+1].imm, tbl[i+1].rwd);
      else in_valid = 1'b0;
    end
    tick();

    // MUL then MULH, 32 busy cycles each
    drive(OPC_MUL, 32'h0001_0003, 32'h0002_0005, 32'h0, 5'd7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("mul_busy_c%0d", i), {busy, in_ready, out_valid}, 3'b100);
      tick();
    end
    check("mul_done", {out_valid, busy}, 2'b10);
    check("mul_res", alu_res_out, 32'h000B_000F);
    check("mul_side", {val_rt_out, rwd_out, opcode_out}, {32'h0002_0005, 5'd7, 6'(OPC_MUL)});
    drive(OPC_MULH, 32'h0001_0003, 32'h0002_0005, 32'h0, 5'd8);
    #1;
    check("mulh_accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("mulh_busy_c%0d", i), {busy, in_ready, out_valid}, 3'b100);
      tick();
    end
    check("mulh_res", {out_valid, alu_res_out}, {1'b1, 32'h0000_0002});
    tick();

    // Backpressure: held slot stays stable, pending op waits, then no bubble
    drive(OPC_ADD, 32'd3, 32'd4, 32'd0, 5'd1);
    tick();
    out_ready = 1'b0;
    drive(OPC_SUB, 32'd10, 32'd4, 32'd0, 5'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_in_ready_c%0d", i), in_ready, 0);
      tick();
      check($sformatf("stall_hold_c%0d", i), {out_valid, alu_res_out, rwd_out, val_rt_out},
            {1'b1, 32'd7, 5'd1, 32'd4});
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("stall_next", {out_valid, alu_res_out, rwd_out}, {1'b1, 32'd6, 5'd2});
    tick();
    check("stall_drained", out_valid, 0);

    // Flush in the middle of a multiply
    drive(OPC_MUL, 32'h0001_0003, 32'h0002_0005, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    drive(OPC_ADD, 32'd1, 32'd1, 32'd0, 5'd3);
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_after", {out_valid, busy}, 2'b00);
    #1;
    check("flush_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("flush_next_op", {out_valid, alu_res_out, rwd_out}, {1'b1, 32'd2, 5'd3});
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("flush_no_mul_c%0d", i), {out_valid, busy}, 2'b00);
    end

    // Reset during BUSY
    drive(OPC_MUL, 32'h1234, 32'h5678, 32'h0, 5'd4);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rst_busy_outputs", {out_valid, val_rt_out, rwd_out, opcode_out, alu_res_out, zf_out, busy}, 0);
    rst = 1'b0;
    #1;
    check("rst_busy_ready", in_ready, 1);
    repeat (40) begin
      tick();
      check("rst_no_result", out_valid, 0);
    end

    // MUL_K = 4 instance: 8-cycle multiply
    k_in_valid = 1'b1; k_op_in = 6'(OPC_MUL); k_rs = 32'h0001_0003; k_rt = 32'h0002_0005;
    k_rwd_in = 5'd5;
    tick();
    k_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("k4_busy_c%0d", i), {k_busy, k_in_ready, k_out_valid}, 3'b100);
      tick();
    end
    check("k4_mul_res", {k_out_valid, k_busy, k_res}, {2'b10, 32'h000B_000F});
    k_in_valid = 1'b1; k_op_in = 6'(OPC_MULH); k_rs = 32'hFFFF_FFFF; k_rt = 32'hFFFF_FFFF;
    tick();
    k_in_valid = 1'b0;
    repeat (8) tick();
    check("k4_mulh_res", {k_out_valid, k_res}, {1'b1, 32'hFFFF_FFFE});

    // Randomised traffic against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_v = 1'b0; m_left = 0;
    m_res = '0; m_rt = '0; m_rwd = '0; m_op = '0;
    p_res = '0; p_rt = '0; p_rwd = '0; p_op = '0;
    for (int c = 0; c < 1500; c++) begin
      opcode_in = ops[$urandom_range(0, 12)];
      val_rs_in = rnd_operand();
      val_rt_in = rnd_operand();
      imm_in    = rnd_operand();
      rwd_in    = 5'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      rdy = (m_left == 0) && !flush && (!m_v || out_ready);
      acc = in_valid && rdy;
      check("rnd_in_ready", in_ready, rdy);
      check("rnd_busy", busy, (m_left != 0));
      check("rnd_out_valid", out_valid, m_v);
      if (m_v) begin
        check("rnd_res", alu_res_out, m_res);
        check("rnd_zf", zf_out, (m_res == 0));
        check("rnd_side", {val_rt_out, rwd_out, opcode_out}, {m_rt, m_rwd, m_op});
      end
      r = ref_res(opcode_in, val_rs_in, uses_imm(32'(opcode_in)) ? imm_in : val_rt_in, imm_in);
      if (32'(opcode_in) == OPC_ADD || 32'(opcode_in) == OPC_SUB || 32'(opcode_in) == OPC_AND ||
          32'(opcode_in) == OPC_OR || 32'(opcode_in) == OPC_XOR || 32'(opcode_in) == OPC_SLT ||
          32'(opcode_in) == OPC_MUL || 32'(opcode_in) == OPC_MULH)
        r = ref_res(opcode_in, val_rs_in, val_rt_in, imm_in);
      @(posedge clk);
      if (flush) begin
        m_v = 1'b0;
        m_left = 0;
      end else begin
        if (m_v && out_ready) m_v = 1'b0;
        if (m_left != 0) begin
          m_left--;
          if (m_left == 0) begin
            m_v = 1'b1; m_res = p_res; m_rt = p_rt; m_rwd = p_rwd; m_op = p_op;
          end
        end
        if (acc) begin
          if (32'(opcode_in) == OPC_MUL || 32'(opcode_in) == OPC_MULH) begin
            p_res = r; p_rt = val_rt_in; p_rwd = rwd_in; p_op = opcode_in;
            m_left = 32;
          end else begin
            m_v = 1'b1; m_res = r; m_rt = val_rt_in; m_rwd = rwd_in; m_op = opcode_in;
          end
        end
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
